// File: rtl/imem_loader.sv
// Loads a big-endian byte stream into instruction memory and releases CPU reset once the image is complete.
// Each word takes 4 accepted bytes plus 1 write cycle; rx_ready is low outside RECV, so the source holds its byte.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] CAP  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ZERO = '0;

  state_t          state;
  state_t          state_nxt;
  logic [ADDR_W:0] target;
  logic [ADDR_W:0] start_target;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] word_cnt_inc;
  logic [1:0]      byte_cnt;
  logic            load;
  logic            take_byte;
  logic            last_word;

  // Requests beyond memory capacity saturate so im_addr can never wrap within a load.
  assign start_target = (word_count > CAP) ? CAP : word_count;
  assign load         = start && ((state == S_IDLE) || (state == S_DONE));
  assign take_byte    = rx_valid && (state == S_RECV);
  assign word_cnt_inc = word_cnt + (ADDR_W + 1)'(1);
  assign last_word    = (word_cnt_inc == target);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    im_we     = 1'b0;
    cpu_rst   = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (start_target == ZERO) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid && (byte_cnt == 2'd3)) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        im_we     = 1'b1;
        busy      = 1'b1;
        state_nxt = last_word ? S_DONE : S_RECV;
      end
      S_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
        if (start) begin
          state_nxt = (start_target == ZERO) ? S_DONE : S_RECV;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target   <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      im_addr  <= '0;
      im_wdata <= '0;
      checksum <= '0;
    end else if (load) begin
      target   <= start_target;
      word_cnt <= '0;
      byte_cnt <= '0;
      im_addr  <= '0;
      im_wdata <= '0;
      checksum <= '0;
    end else begin
      if (take_byte) begin
        // Shift-in gives big-endian packing: the first byte ends up in [31:24].
        im_wdata <= {im_wdata[23:0], rx_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == S_WRITE) begin
        checksum <= checksum + im_wdata;
        word_cnt <= word_cnt_inc;
        if (!last_word) begin
          im_addr <= im_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule
